sdram_frame_reader: RTL

- Display-side SDRAM reader for the triple-buffered camera-to-VGA path.
- On each display frame start, latches the current vga_bank and streams one full frame from that bank, as fixed-length read bursts, into the VGA line FIFO.
- Drives vga_rise, a frame-busy level. The bank switcher uses its falling edge to retire the bank and move to the newest full bank.

---
 rtl/sdram_frame_reader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sdram_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_frame_reader
//  Purpose  : Display-side SDRAM reader. Streams one frame from the latched
//             bank as fixed-length read bursts into the VGA line FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module sdram_frame_reader #(
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 480,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 512,
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              rst_133,
    input  logic              frame_start,
    input  logic [1:0]        vga_bank,
    output logic              vga_rise,
    output logic              rd_req,
    output logic [ADDR_W+1:0] rd_addr,
    input  logic              rd_ack,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [9:0]        fifo_usedw,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              frame_overrun,
    output logic              fifo_err
);

    localparam int unsigned c_FRAME_WORDS = H_PIXELS * V_LINES;
    localparam int unsigned c_SPACE_LIMIT = FIFO_DEPTH - BURST_LEN;
    localparam int          c_BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST  = c_BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0]   c_BURST_STEP = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0]   c_LAST_ADDR  = ADDR_W'(c_FRAME_WORDS - BURST_LEN);

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_WAIT_SPACE = 3'd1;
    localparam logic [2:0] c_ST_REQ        = 3'd2;
    localparam logic [2:0] c_ST_DATA       = 3'd3;
    localparam logic [2:0] c_ST_DONE       = 3'd4;

    logic [2:0]          r_state;
    logic [1:0]          r_bank_lat;
    logic [ADDR_W-1:0]   r_word_addr;
    logic [c_BEAT_W-1:0] r_beat_cnt;
    logic                r_vga_rise;
    logic                r_rd_req;
    logic [ADDR_W+1:0]   r_rd_addr;
    logic                r_fifo_wr_en;
    logic [DATA_W-1:0]   r_fifo_wr_data;
    logic                r_frame_overrun;
    logic                r_fifo_err;
    logic                w_space_ok;

    assign w_space_ok = (32'(fifo_usedw) <= c_SPACE_LIMIT);

    always_ff @(posedge clk) begin
        if (rst_133) begin
            r_state         <= c_ST_IDLE;
            r_bank_lat      <= '0;
            r_word_addr     <= '0;
            r_beat_cnt      <= '0;
            r_vga_rise      <= 1'b0;
            r_rd_req        <= 1'b0;
            r_rd_addr       <= '0;
            r_fifo_wr_en    <= 1'b0;
            r_fifo_wr_data  <= '0;
            r_frame_overrun <= 1'b0;
            r_fifo_err      <= 1'b0;
        end else begin
            r_fifo_wr_en    <= 1'b0;
            r_frame_overrun <= frame_start && (r_state != c_ST_IDLE);
            // The error reflects the strobe actually presented to a full FIFO
            if (r_fifo_wr_en && fifo_full)
                r_fifo_err <= 1'b1;

            case (r_state)
                c_ST_IDLE: begin
                    if (frame_start) begin
                        r_bank_lat  <= vga_bank;
                        r_word_addr <= '0;
                        r_vga_rise  <= 1'b1;
                        r_state     <= c_ST_WAIT_SPACE;
                    end
                end
                c_ST_WAIT_SPACE: begin
                    if (w_space_ok) begin
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= {r_bank_lat, r_word_addr};
                        r_state   <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (rd_ack) begin
                        r_rd_req   <= 1'b0;
                        r_beat_cnt <= '0;
                        r_state    <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (rd_valid) begin
                        r_fifo_wr_en   <= 1'b1;
                        r_fifo_wr_data <= rd_data;
                        r_beat_cnt     <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == c_BEAT_LAST) begin
                            r_word_addr <= r_word_addr + c_BURST_STEP;
                            r_state     <= (r_word_addr == c_LAST_ADDR) ? c_ST_DONE
                                                                        : c_ST_WAIT_SPACE;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_vga_rise <= 1'b0;
                    r_state    <= c_ST_IDLE;
                end
                default: begin
                    r_vga_rise <= 1'b0;
                    r_rd_req   <= 1'b0;
                    r_state    <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign vga_rise      = r_vga_rise;
    assign rd_req        = r_rd_req;
    assign rd_addr       = r_rd_addr;
    assign fifo_wr_en    = r_fifo_wr_en;
    assign fifo_wr_data  = r_fifo_wr_data;
    assign frame_overrun = r_frame_overrun;
    assign fifo_err      = r_fifo_err;

endmodule
`default_nettype wire
